// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: shared definitions for the instruction stream encoder.
//   - 6-bit opcode map used by the core's decode (OP_RTYPE..OP_JALFOR)
//   - 4-bit op_class encoding presented on the symbolic instruction stream
//   - packed field bundle handed from the top to the word encoder
//   - loader FSM state encoding
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b110000;
  localparam logic [5:0] OP_LW     = 6'b110001;
  localparam logic [5:0] OP_SW     = 6'b110010;
  localparam logic [5:0] OP_BEQ    = 6'b110011;
  localparam logic [5:0] OP_BNE    = 6'b110100;
  localparam logic [5:0] OP_ADDI   = 6'b110101;
  localparam logic [5:0] OP_J      = 6'b110110;
  localparam logic [5:0] OP_JAL    = 6'b110111;
  localparam logic [5:0] OP_JALFOR = 6'b111000;

  // Classes 9..15 are deliberately not enumerated: they are illegal.
  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_LW     = 4'd1,
    CLS_SW     = 4'd2,
    CLS_BEQ    = 4'd3,
    CLS_BNE    = 4'd4,
    CLS_ADDI   = 4'd5,
    CLS_J      = 4'd6,
    CLS_JAL    = 4'd7,
    CLS_JALFOR = 4'd8
  } op_class_e;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } instr_fields_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_word_encoder.sv
// instr_word_encoder: combinational op_class + fields -> 32-bit instruction word.
// Ports:
//   op_class  in   4    symbolic instruction class
//   fields    in   -    register/immediate/target fields (unused ones ignored)
//   word      out  32   encoded word (0 for illegal classes)
//   illegal   out  1    op_class has no encoding
module instr_word_encoder
  import mips_isa_pkg::*;
(
  input  logic [3:0]    op_class,
  input  instr_fields_t fields,
  output logic [31:0]   word,
  output logic          illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op_class)
      CLS_R:      word = {OP_RTYPE, fields.rs, fields.rt, fields.rd, fields.shamt, fields.funct};
      CLS_LW:     word = {OP_LW,    fields.rs, fields.rt, fields.imm};
      CLS_SW:     word = {OP_SW,    fields.rs, fields.rt, fields.imm};
      CLS_BEQ:    word = {OP_BEQ,   fields.rs, fields.rt, fields.imm};
      CLS_BNE:    word = {OP_BNE,   fields.rs, fields.rt, fields.imm};
      CLS_ADDI:   word = {OP_ADDI,  fields.rs, fields.rt, fields.imm};
      CLS_J:      word = {OP_J,      fields.target};
      CLS_JAL:    word = {OP_JAL,    fields.target};
      CLS_JALFOR: word = {OP_JALFOR, fields.target};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: program loader. Accepts symbolic instructions on a
// valid/ready stream, encodes them and writes them to consecutive
// instruction-memory addresses (1-cycle write latency, 1 word/cycle).
// Optional feature: define INSTR_ENC_CHECKSUM_EN to build a running XOR of
// every written word; otherwise checksum is tied to 0.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               begin a load (only honoured in IDLE)
//   base_addr           first write address, latched on start
//   word_count          instructions to accept, latched on start
//   in_valid/in_ready   instruction stream handshake
//   op_class, rs, rt, rd, shamt, funct, imm, target   instruction fields
//   imem_we/addr/wdata  instruction-memory write port
//   busy                load in progress
//   done                one-cycle completion pulse
//   err_illegal         sticky illegal-class flag, cleared on start
//   checksum            XOR of written words
module instr_stream_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_class,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [31:0]       checksum
);

  state_e            state;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] ptr;

  instr_fields_t fields;
  logic [31:0]   enc_word;
  logic          enc_illegal;

  assign fields.rs     = rs;
  assign fields.rt     = rt;
  assign fields.rd     = rd;
  assign fields.shamt  = shamt;
  assign fields.funct  = funct;
  assign fields.imm    = imm;
  assign fields.target = target;

  instr_word_encoder u_enc (
    .op_class (op_class),
    .fields   (fields),
    .word     (enc_word),
    .illegal  (enc_illegal)
  );

  // in_ready is a flop that mirrors "state is LOAD", so it never depends
  // combinationally on in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      ptr         <= '0;
      in_ready    <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ptr         <= base_addr;
            remaining   <= word_count;
            err_illegal <= 1'b0;
            busy        <= 1'b1;
            if (word_count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (in_valid && in_ready) begin
            remaining <= remaining - CNT_W'(1);
            // Illegal classes consume a slot but never reach memory.
            if (enc_illegal) begin
              err_illegal <= 1'b1;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= ptr;
              imem_wdata <= enc_word;
              ptr        <= ptr + ADDR_W'(1);
            end
            if (remaining == CNT_W'(1)) begin
              state    <= ST_FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        // The last write is on the port during FLUSH.
        ST_FLUSH: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef INSTR_ENC_CHECKSUM_EN
  // start is only honoured in IDLE, where no write is ever on the port.
  always_ff @(posedge clk) begin
    if (reset)                        checksum <= '0;
    else if (state == ST_IDLE && start) checksum <= '0;
    else if (imem_we)                 checksum <= checksum ^ imem_wdata;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_stream_encoder.sv
module tb_instr_stream_encoder;
  import mips_isa_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  word_count;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_class;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err_illegal;
  logic [31:0] checksum;

  int n_chk = 0;
  int n_err = 0;

  instr_stream_encoder #(.ADDR_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm(imm), .target(target), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
    .done(done), .err_illegal(err_illegal), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fields;
    op_class = '0; rs = '0; rt = '0; rd = '0; shamt = '0;
    funct = '0; imm = '0; target = '0;
  endtask

  task automatic set_r(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic [4:0] sh, input logic [5:0] fn);
    clr_fields();
    op_class = CLS_R; rs = a; rt = b; rd = d; shamt = sh; funct = fn;
  endtask

  task automatic set_i(input logic [3:0] c, input logic [4:0] a, input logic [4:0] b,
                       input logic [15:0] i);
    clr_fields();
    op_class = c; rs = a; rt = b; imm = i;
  endtask

  task automatic set_j(input logic [3:0] c, input logic [25:0] t);
    clr_fields();
    op_class = c; target = t;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [7:0] n);
    start = 1'b1; base_addr = b; word_count = n;
    step();
    start = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic [7:0] a, input logic [31:0] w);
    chk({tag, "_we"},   {31'b0, imem_we}, 32'd1);
    chk({tag, "_addr"}, {24'b0, imem_addr}, {24'b0, a});
    chk({tag, "_data"}, imem_wdata, w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_sum;
`ifdef INSTR_ENC_CHECKSUM_EN
    exp_sum = 32'h0000_0001;
`else
    exp_sum = 32'h0;
`endif
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; in_valid = 1'b0;
    clr_fields();
    step(); step();
    chk("rst_ready", {31'b0, in_ready}, 0);
    chk("rst_we",    {31'b0, imem_we}, 0);
    chk("rst_busy",  {31'b0, busy}, 0);
    chk("rst_done",  {31'b0, done}, 0);
    chk("rst_err",   {31'b0, err_illegal}, 0);
    chk("rst_addr",  {24'b0, imem_addr}, 0);
    chk("rst_data",  imem_wdata, 0);
    chk("rst_sum",   checksum, 0);
    reset = 1'b0;
    step();

    // 1: single LW
    do_start(8'h10, 8'd1);
    chk("t1_ready", {31'b0, in_ready}, 1);
    chk("t1_busy",  {31'b0, busy}, 1);
    set_i(CLS_LW, 5'd2, 5'd3, 16'h0010); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    chk_wr("t1", 8'h10, 32'hC443_0010);
    chk("t1_nodone", {31'b0, done}, 0);
    step();
    chk("t1_done", {31'b0, done}, 1);
    chk("t1_we0",  {31'b0, imem_we}, 0);
    step();
    chk("t1_done0", {31'b0, done}, 0);
    chk("t1_idle",  {31'b0, busy}, 0);

    // 2: back-to-back R then J
    do_start(8'h10, 8'd2);
    set_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20); in_valid = 1'b1;
    step();
    chk_wr("t2a", 8'h10, 32'hC022_1820);
    set_j(CLS_J, 26'h40);
    step(); in_valid = 1'b0;
    chk_wr("t2b", 8'h11, 32'hD800_0040);
    step();
    chk("t2_done", {31'b0, done}, 1);
    step();

    // 3: address wrap
    do_start(8'hFF, 8'd2);
    set_i(CLS_ADDI, 5'd1, 5'd2, 16'h0005); in_valid = 1'b1;
    step();
    chk_wr("t3a", 8'hFF, 32'hD422_0005);
    set_i(CLS_ADDI, 5'd1, 5'd2, 16'h0006);
    step(); in_valid = 1'b0;
    chk_wr("t3b", 8'h00, 32'hD422_0006);
    step();
    chk("t3_done", {31'b0, done}, 1);
    step();

    // 4: illegal class in the middle
    do_start(8'h20, 8'd3);
    set_i(CLS_SW, 5'd4, 5'd5, 16'h0008); in_valid = 1'b1;
    step();
    chk_wr("t4a", 8'h20, 32'hC885_0008);
    clr_fields(); op_class = 4'd12;
    step();
    chk("t4_ill_we", {31'b0, imem_we}, 0);
    chk("t4_err",    {31'b0, err_illegal}, 1);
    set_i(CLS_BEQ, 5'd6, 5'd7, 16'hFFFF);
    step(); in_valid = 1'b0;
    chk_wr("t4b", 8'h21, 32'hCCC7_FFFF);
    step();
    chk("t4_done", {31'b0, done}, 1);
    step();
    chk("t4_err_held", {31'b0, err_illegal}, 1);

    // 5: zero count, then start ignored during LOAD
    do_start(8'h40, 8'd0);
    chk("t5_done",   {31'b0, done}, 1);
    chk("t5_we",     {31'b0, imem_we}, 0);
    chk("t5_errclr", {31'b0, err_illegal}, 0);
    step();
    chk("t5_idle", {31'b0, busy}, 0);
    do_start(8'h30, 8'd2);
    start = 1'b1; base_addr = 8'h50; word_count = 8'd5;
    step(); start = 1'b0;
    chk("t5_ready", {31'b0, in_ready}, 1);
    set_i(CLS_LW, 5'd1, 5'd1, 16'h0001); in_valid = 1'b1;
    step();
    chk_wr("t5a", 8'h30, 32'hC421_0001);
    step(); in_valid = 1'b0;
    chk_wr("t5b", 8'h31, 32'hC421_0001);
    step();
    chk("t5_done2", {31'b0, done}, 1);
    step();

    // 6: checksum, then reset during the write cycle
    do_start(8'h00, 8'd2);
    set_j(CLS_JALFOR, 26'h0); in_valid = 1'b1;
    step();
    chk_wr("t6a", 8'h00, 32'hE000_0000);
    set_j(CLS_JALFOR, 26'h1);
    step(); in_valid = 1'b0;
    chk_wr("t6b", 8'h01, 32'hE000_0001);
    step();
    chk("t6_done", {31'b0, done}, 1);
    chk("t6_sum",  checksum, exp_sum);
    step();
    do_start(8'h60, 8'd1);
    set_i(CLS_LW, 5'd2, 5'd3, 16'h0010); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    chk("t6_pre_we", {31'b0, imem_we}, 1);
    reset = 1'b1;
    step();
    chk("t6r_we",    {31'b0, imem_we}, 0);
    chk("t6r_done",  {31'b0, done}, 0);
    chk("t6r_busy",  {31'b0, busy}, 0);
    chk("t6r_ready", {31'b0, in_ready}, 0);
    chk("t6r_addr",  {24'b0, imem_addr}, 0);
    chk("t6r_data",  imem_wdata, 0);
    chk("t6r_sum",   checksum, 0);
    step();
    chk("t6r_done2", {31'b0, done}, 0);
    reset = 1'b0;
    step();
    chk("t6r_idle", {31'b0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
